// File: rtl/dff_response_checker.sv
// Streaming checker for dff_re simulation records: golden resettable-enabled DFF,
// mismatch accounting, first-failure capture and timestamp-order monitoring.
module dff_response_checker #(
  parameter int TS_WIDTH     = 32,
  parameter int CNT_WIDTH    = 16,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TS_WIDTH-1:0]  rec_ts,
  input  logic                 rec_clk,
  input  logic                 rec_rst_n,
  input  logic                 rec_enable,
  input  logic                 rec_d,
  input  logic                 rec_q,
  input  logic                 end_of_test,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic [CNT_WIDTH-1:0] mismatch_count,
  output logic                 first_fail_vld,
  output logic [TS_WIDTH-1:0]  first_fail_ts,
  output logic                 ts_error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic                 STOP_EN = (STOP_ON_FAIL != 0);

  state_e                state_q, state_d;
  logic                  exp_bit_q, exp_bit_d;
  logic                  prev_clk_q, prev_clk_d;
  logic                  have_ts_q, have_ts_d;
  logic [TS_WIDTH-1:0]   prev_ts_q, prev_ts_d;
  logic [CNT_WIDTH-1:0]  sample_cnt_q, sample_cnt_d;
  logic [CNT_WIDTH-1:0]  mismatch_cnt_q, mismatch_cnt_d;
  logic                  ff_vld_q, ff_vld_d;
  logic [TS_WIDTH-1:0]   ff_ts_q, ff_ts_d;
  logic                  ts_err_q, ts_err_d;

  logic beat_s;
  logic exp_new_s;
  logic mismatch_s;
  logic ts_bad_s;

  assign beat_s = in_valid & in_ready;

  // Golden DFF for the current record; the record is post-edge, so d comes from it
  always_comb begin
    exp_new_s = exp_bit_q;
    if (!rec_rst_n) begin
      exp_new_s = 1'b0;
    end else if (!prev_clk_q && rec_clk && rec_enable) begin
      exp_new_s = rec_d;
    end else begin
      exp_new_s = exp_bit_q;
    end
    mismatch_s = beat_s && (rec_q != exp_new_s);
    ts_bad_s   = beat_s && have_ts_q && (rec_ts <= prev_ts_q);
  end

  // Datapath next-state: model, counters and sticky flags advance only on beats
  always_comb begin
    exp_bit_d      = exp_bit_q;
    prev_clk_d     = prev_clk_q;
    have_ts_d      = have_ts_q;
    prev_ts_d      = prev_ts_q;
    sample_cnt_d   = sample_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    ff_vld_d       = ff_vld_q;
    ff_ts_d        = ff_ts_q;
    ts_err_d       = ts_err_q | ts_bad_s;
    if (beat_s) begin
      exp_bit_d    = exp_new_s;
      prev_clk_d   = rec_clk;
      have_ts_d    = 1'b1;
      prev_ts_d    = rec_ts;
      sample_cnt_d = (sample_cnt_q == CNT_MAX) ? sample_cnt_q : sample_cnt_q + CNT_ONE;
      if (mismatch_s) begin
        mismatch_cnt_d = (mismatch_cnt_q == CNT_MAX) ? mismatch_cnt_q : mismatch_cnt_q + CNT_ONE;
        if (!ff_vld_q) begin
          ff_vld_d = 1'b1;
          ff_ts_d  = rec_ts;
        end else begin
          ff_vld_d = ff_vld_q;
        end
      end else begin
        mismatch_cnt_d = mismatch_cnt_q;
      end
    end else begin
      sample_cnt_d = sample_cnt_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_bit_q      <= 1'b0;
      prev_clk_q     <= 1'b0;
      have_ts_q      <= 1'b0;
      prev_ts_q      <= '0;
      sample_cnt_q   <= '0;
      mismatch_cnt_q <= '0;
      ff_vld_q       <= 1'b0;
      ff_ts_q        <= '0;
      ts_err_q       <= 1'b0;
    end else begin
      exp_bit_q      <= exp_bit_d;
      prev_clk_q     <= prev_clk_d;
      have_ts_q      <= have_ts_d;
      prev_ts_q      <= prev_ts_d;
      sample_cnt_q   <= sample_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      ff_vld_q       <= ff_vld_d;
      ff_ts_q        <= ff_ts_d;
      ts_err_q       <= ts_err_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a beat coinciding with end_of_test is still accounted above
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (end_of_test || (STOP_EN && mismatch_s)) begin
          state_d = S_DONE;
        end else if (beat_s) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (end_of_test || (STOP_EN && mismatch_s)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; DONE freezes the datapath by withdrawing in_ready
  always_comb begin
    in_ready = 1'b1;
    done     = 1'b0;
    pass     = 1'b0;
    case (state_q)
      S_DONE: begin
        in_ready = 1'b0;
        done     = 1'b1;
        pass     = (mismatch_cnt_q == '0) && !ts_err_q;
      end
      default: begin
        in_ready = 1'b1;
        done     = 1'b0;
        pass     = 1'b0;
      end
    endcase
  end

  assign sample_count   = sample_cnt_q;
  assign mismatch_count = mismatch_cnt_q;
  assign first_fail_vld = ff_vld_q;
  assign first_fail_ts  = ff_ts_q;
  assign ts_error       = ts_err_q;

endmodule

// File: tb/tb_dff_response_checker.sv
// Scoreboard bench: three checker variants (default, stop-on-fail, 4-bit counters)
// share one record stream and are compared against a behavioural reference.
module tb_dff_response_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] rec_ts = 32'd0;
  logic        rec_clk = 1'b0, rec_rst_n = 1'b1, rec_enable = 1'b0, rec_d = 1'b0, rec_q = 1'b0;
  logic        end_of_test = 1'b0;

  logic        rdy0, done0, pass0, ffv0, tse0;
  logic [15:0] sc0, mc0;
  logic [31:0] ffts0;
  logic        rdy1, done1, pass1, ffv1, tse1;
  logic [15:0] sc1, mc1;
  logic [31:0] ffts1;
  logic        rdy2, done2, pass2, ffv2, tse2;
  logic [3:0]  sc2, mc2;
  logic [31:0] ffts2;

  always #5 clk = ~clk;

  dff_response_checker #(.TS_WIDTH(32), .CNT_WIDTH(16), .STOP_ON_FAIL(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .rec_ts(rec_ts),
    .rec_clk(rec_clk), .rec_rst_n(rec_rst_n), .rec_enable(rec_enable), .rec_d(rec_d),
    .rec_q(rec_q), .end_of_test(end_of_test), .done(done0), .pass(pass0),
    .sample_count(sc0), .mismatch_count(mc0), .first_fail_vld(ffv0),
    .first_fail_ts(ffts0), .ts_error(tse0));

  dff_response_checker #(.TS_WIDTH(32), .CNT_WIDTH(16), .STOP_ON_FAIL(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .rec_ts(rec_ts),
    .rec_clk(rec_clk), .rec_rst_n(rec_rst_n), .rec_enable(rec_enable), .rec_d(rec_d),
    .rec_q(rec_q), .end_of_test(end_of_test), .done(done1), .pass(pass1),
    .sample_count(sc1), .mismatch_count(mc1), .first_fail_vld(ffv1),
    .first_fail_ts(ffts1), .ts_error(tse1));

  dff_response_checker #(.TS_WIDTH(32), .CNT_WIDTH(4), .STOP_ON_FAIL(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .rec_ts(rec_ts),
    .rec_clk(rec_clk), .rec_rst_n(rec_rst_n), .rec_enable(rec_enable), .rec_d(rec_d),
    .rec_q(rec_q), .end_of_test(end_of_test), .done(done2), .pass(pass2),
    .sample_count(sc2), .mismatch_count(mc2), .first_fail_vld(ffv2),
    .first_fail_ts(ffts2), .ts_error(tse2));

  // Reference: per-variant accounting of an ideal checker over the record stream
  typedef struct {
    int unsigned samples;
    int unsigned mism;
    bit          ffv;
    int unsigned ffts;
    bit          tse;
    bit          have_ts;
    int unsigned prev_ts;
    bit          fin;
  } acct_t;

  typedef struct {
    bit          pass;
    int unsigned sc;
    int unsigned mc;
    bit          ffv;
    int unsigned ffts;
    bit          tse;
  } verdict_t;

  acct_t       m [3];
  int unsigned cmax  [3] = '{65535, 65535, 15};
  bit          stopv [3] = '{1'b0, 1'b1, 1'b0};
  bit          gold_q, gold_clk;
  verdict_t    bq[$], vq0[$], vq1[$], vq2[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int unsigned sat(input int unsigned x, input int k);
    return (x > cmax[k]) ? cmax[k] : x;
  endfunction

  function automatic verdict_t snap(input int k);
    verdict_t v;
    v.pass = (m[k].mism == 0) && !m[k].tse;
    v.sc   = sat(m[k].samples, k);
    v.mc   = sat(m[k].mism, k);
    v.ffv  = m[k].ffv;
    v.ffts = m[k].ffts;
    v.tse  = m[k].tse;
    return v;
  endfunction

  task automatic finish_v(input int k);
    m[k].fin = 1'b1;
    case (k)
      0:       vq0.push_back(snap(0));
      1:       vq1.push_back(snap(1));
      default: vq2.push_back(snap(2));
    endcase
  endtask

  task automatic account(input int k, input int unsigned ts, input bit mis);
    if (m[k].fin) return;
    m[k].samples++;
    if (mis) begin
      m[k].mism++;
      if (!m[k].ffv) begin
        m[k].ffv  = 1'b1;
        m[k].ffts = ts;
      end
    end
    if (m[k].have_ts && ts <= m[k].prev_ts) m[k].tse = 1'b1;
    m[k].have_ts = 1'b1;
    m[k].prev_ts = ts;
    if (stopv[k] && mis) finish_v(k);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m[k] = '{default: 0};
    gold_q   = 1'b0;
    gold_clk = 1'b0;
  endtask

  // One cycle of stimulus; q is the golden value, inverted when flip is set
  task automatic drive(input bit v, input int unsigned ts, input bit c, input bit rn,
                       input bit en, input bit d, input bit flip, input bit eot);
    bit g;
    bit was_fin0;
    @(negedge clk);
    g = gold_q;
    if (!rn) g = 1'b0;
    else if (!gold_clk && c && en) g = d;
    if (v) begin
      was_fin0 = m[0].fin;
      gold_q   = g;
      gold_clk = c;
      for (int k = 0; k < 3; k++) account(k, ts, flip);
      if (!was_fin0) bq.push_back(snap(0));
    end
    if (eot) begin
      for (int k = 0; k < 3; k++) if (!m[k].fin) finish_v(k);
    end
    in_valid    = v;
    rec_ts      = ts;
    rec_clk     = c;
    rec_rst_n   = rn;
    rec_enable  = en;
    rec_d       = d;
    rec_q       = g ^ flip;
    end_of_test = eot;
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bq.size() == 0 && vq0.size() == 0 && vq1.size() == 0 && vq2.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_timeout", ok, 1);
  endtask

  task automatic final_counts();
    chk("sc0_final", sc0, sat(m[0].samples, 0));
    chk("mc0_final", mc0, sat(m[0].mism, 0));
    chk("sc1_final", sc1, sat(m[1].samples, 1));
    chk("mc1_final", mc1, sat(m[1].mism, 1));
    chk("sc2_final", sc2, sat(m[2].samples, 2));
    chk("mc2_final", mc2, sat(m[2].mism, 2));
  endtask

  // Asserted between clock edges so the asynchronous clear is observed at once
  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    in_valid    = 1'b0;
    end_of_test = 1'b0;
    #1;
    chk("rst_ready", {rdy2, rdy1, rdy0}, 7);
    chk("rst_done", {done2, done1, done0}, 0);
    chk("rst_pass", {pass2, pass1, pass0}, 0);
    chk("rst_counts", {sc0, mc0}, 0);
    chk("rst_ff", {ffv0, ffts0}, 0);
    chk("rst_tserr", tse0, 0);
    model_reset();
    bq.delete(); vq0.delete(); vq1.delete(); vq2.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic vcheck(input string tag, input verdict_t e, input bit p, input int unsigned sc,
                        input int unsigned mc, input bit ffv, input int unsigned ffts,
                        input bit tse, input bit rdy);
    chk({tag, "_pass"}, p, e.pass);
    chk({tag, "_sc"}, sc, e.sc);
    chk({tag, "_mc"}, mc, e.mc);
    chk({tag, "_ffv"}, ffv, e.ffv);
    chk({tag, "_ffts"}, ffts, e.ffts);
    chk({tag, "_tse"}, tse, e.tse);
    chk({tag, "_rdy"}, rdy, 0);
  endtask

  // Monitor: a sample_count step on dut0 is one presented beat, a done rise a verdict
  initial begin
    int unsigned last_sc = 0;
    bit [2:0]    dprev   = 3'b000;
    verdict_t    e;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        last_sc = 0;
        dprev   = 3'b000;
      end else begin
        if (sc0 != last_sc[15:0]) begin
          if (bq.size() == 0) begin
            chk("beat_unexpected", sc0, last_sc);
          end else begin
            e = bq.pop_front();
            chk("beat_sc", sc0, e.sc);
            chk("beat_mc", mc0, e.mc);
            chk("beat_ffv", ffv0, e.ffv);
            chk("beat_ffts", ffts0, e.ffts);
            chk("beat_tse", tse0, e.tse);
          end
          last_sc = sc0;
        end
        if (done0 && !dprev[0]) begin
          if (vq0.size() == 0) chk("done0_unexpected", done0, 0);
          else vcheck("v0", vq0.pop_front(), pass0, sc0, mc0, ffv0, ffts0, tse0, rdy0);
        end
        if (done1 && !dprev[1]) begin
          if (vq1.size() == 0) chk("done1_unexpected", done1, 0);
          else vcheck("v1", vq1.pop_front(), pass1, sc1, mc1, ffv1, ffts1, tse1, rdy1);
        end
        if (done2 && !dprev[2]) begin
          if (vq2.size() == 0) chk("done2_unexpected", done2, 0);
          else vcheck("v2", vq2.pop_front(), pass2, sc2, mc2, ffv2, ffts2, tse2, rdy2);
        end
        dprev = {done2, done1, done0};
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned ts;
    model_reset();
    do_reset();

    // Reset beat, then enabled rising edges with d=1,0,1, all matching
    drive(1, 10, 0, 0, 1, 0, 0, 0);
    drive(1, 20, 1, 1, 1, 1, 0, 0);
    drive(1, 30, 0, 1, 1, 0, 0, 0);
    drive(1, 40, 1, 1, 1, 0, 0, 0);
    drive(1, 50, 0, 1, 1, 1, 0, 0);
    drive(1, 60, 1, 1, 1, 1, 0, 1);
    drive(1, 70, 0, 1, 1, 1, 1, 0);
    idle();
    drain();
    chk("t1_pass", pass0, 1);
    final_counts();
    do_reset();

    // Disabled edge with q=1 at ts=40, second failure at ts=60
    drive(1, 10, 0, 1, 1, 0, 0, 0);
    drive(1, 20, 1, 1, 1, 0, 0, 0);
    drive(1, 30, 0, 1, 0, 1, 0, 0);
    drive(1, 40, 1, 1, 0, 1, 1, 0);
    drive(1, 50, 0, 1, 0, 1, 0, 0);
    drive(1, 60, 1, 1, 0, 1, 1, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 1);
    idle();
    drain();
    chk("t2_ffts", ffts0, 40);
    chk("t2_mc", mc0, 2);
    final_counts();
    do_reset();

    // Mismatch at beat 3 stops the stop-on-fail variant
    drive(1, 10, 0, 1, 1, 0, 0, 0);
    drive(1, 20, 1, 1, 1, 1, 0, 0);
    drive(1, 30, 0, 1, 1, 0, 1, 0);
    drive(1, 40, 1, 1, 1, 0, 0, 0);
    drive(1, 50, 0, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 1);
    idle();
    drain();
    chk("t3_sc1", sc1, 3);
    chk("t3_rdy1", rdy1, 0);
    final_counts();
    do_reset();

    // Repeated timestamp
    drive(1, 10, 0, 1, 0, 0, 0, 0);
    drive(1, 20, 0, 1, 0, 0, 0, 0);
    drive(1, 20, 0, 1, 0, 0, 0, 0);
    drive(1, 30, 0, 1, 0, 0, 0, 1);
    idle();
    drain();
    chk("t4_tse", tse0, 1);
    chk("t4_pass", pass0, 0);
    final_counts();
    do_reset();

    // Twenty mismatches saturate the 4-bit counter
    for (int i = 0; i < 20; i++) drive(1, 10 * (i + 1), 0, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 1);
    idle();
    drain();
    chk("t5_mc2", mc2, 15);
    chk("t5_pass2", pass2, 0);
    final_counts();
    do_reset();

    // Mid-run reset, then a fresh two-beat stream
    drive(1, 10, 0, 1, 1, 1, 0, 0);
    drive(1, 20, 1, 1, 1, 1, 1, 0);
    drive(1, 30, 0, 1, 1, 0, 0, 0);
    idle();
    drain();
    do_reset();
    drive(1, 5, 0, 1, 1, 1, 0, 0);
    drive(1, 6, 1, 1, 1, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 1);
    idle();
    drain();
    chk("t6_sc", sc0, 2);
    chk("t6_pass", pass0, 1);
    final_counts();
    do_reset();

    // Empty stream
    drive(0, 0, 0, 1, 0, 0, 0, 1);
    idle();
    drain();
    chk("t7_pass", pass0, 1);
    do_reset();

    // Randomised streams
    for (int s = 0; s < 30; s++) begin
      int len;
      bit mid_rst;
      len     = $urandom_range(0, 20);
      mid_rst = ($urandom_range(0, 9) == 0);
      ts      = $urandom_range(1, 100);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 4) == 0) idle();
        if ($urandom_range(0, 14) == 0) ts = ts - $urandom_range(0, 3);
        else ts = ts + $urandom_range(1, 20);
        drive(1, ts, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) == 0), (!mid_rst && i == len - 1 && $urandom_range(0, 1) == 1));
      end
      if (!mid_rst && !m[0].fin) drive(0, 0, 0, 1, 0, 0, 0, 1);
      if (!mid_rst && $urandom_range(0, 1) == 1) drive(1, ts + 1, 1, 1, 1, 1, 1, 0);
      idle();
      drain();
      final_counts();
      do_reset();
    end

    chk("queues_empty", bq.size() + vq0.size() + vq1.size() + vq2.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
